// File: rtl/mem_if_pkg.sv
// Shared types and limits for the RC4 memory read/write controller.
package mem_if_pkg;

  localparam int MEM_IF_MAX_RD_LAT = 15;
  localparam int MEM_IF_CNT_W      = $clog2(MEM_IF_MAX_RD_LAT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    WR_DONE = 3'd2,
    RD_WAIT = 3'd3,
    RD_CAP  = 3'd4,
    RD_DONE = 3'd5
  } mem_if_state_t;

endpackage

// File: rtl/mem_rw_interface.sv
// Single-port memory controller: one-cycle writes and fixed-latency reads,
// with a read queued behind a write when both start together.
module mem_rw_interface
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              wr_start,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [DATA_W-1:0] wr_data_in,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic [DATA_W-1:0] rd_mem,
  output logic [ADDR_W-1:0] addr_mem,
  output logic [DATA_W-1:0] wr_mem,
  output logic              wr_enable,
  output logic              wr_done,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy
);

  if (RD_LAT < 1 || RD_LAT > MEM_IF_MAX_RD_LAT) begin : g_bad_rd_lat
    $error("mem_rw_interface: RD_LAT must be in 1..%0d", MEM_IF_MAX_RD_LAT);
  end

  localparam logic [MEM_IF_CNT_W-1:0] LAT_LOAD = MEM_IF_CNT_W'(RD_LAT - 1);

  mem_if_state_t           state_q, state_d;
  logic [ADDR_W-1:0]       addr_mem_q, addr_mem_d;
  logic [DATA_W-1:0]       wr_mem_q, wr_mem_d;
  logic [DATA_W-1:0]       rd_data_q, rd_data_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]       rd_pend_addr_q, rd_pend_addr_d;
  logic [MEM_IF_CNT_W-1:0] cnt_q, cnt_d;
  logic                    wr_enable_q, wr_enable_d;
  logic                    wr_done_q, wr_done_d;
  logic                    rd_done_q, rd_done_d;

  always_comb begin
    state_d        = state_q;
    addr_mem_d     = addr_mem_q;
    wr_mem_d       = wr_mem_q;
    rd_data_d      = rd_data_q;
    rd_pend_d      = rd_pend_q;
    rd_pend_addr_d = rd_pend_addr_q;
    cnt_d          = cnt_q;
    case (state_q)
      IDLE: begin
        if (wr_start) begin
          addr_mem_d = wr_addr_in;
          wr_mem_d   = wr_data_in;
          state_d    = WRITE;
          // A read arriving with the write waits until the write has landed.
          if (rd_start) begin
            rd_pend_d      = 1'b1;
            rd_pend_addr_d = rd_addr_in;
          end
        end else if (rd_start) begin
          addr_mem_d = rd_addr_in;
          cnt_d      = LAT_LOAD;
          state_d    = RD_WAIT;
        end
      end
      WRITE: state_d = WR_DONE;
      WR_DONE: begin
        if (rd_pend_q) begin
          addr_mem_d = rd_pend_addr_q;
          rd_pend_d  = 1'b0;
          cnt_d      = LAT_LOAD;
          state_d    = RD_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) state_d = RD_CAP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RD_CAP: begin
        rd_data_d = rd_mem;
        state_d   = RD_DONE;
      end
      RD_DONE: state_d = IDLE;
      default: begin
        state_d   = IDLE;
        rd_pend_d = 1'b0;
      end
    endcase
  end

  // Strobes are registered off the next state so they line up with it.
  always_comb begin
    wr_enable_d = (state_d == WRITE);
    wr_done_d   = (state_d == WR_DONE);
    rd_done_d   = (state_d == RD_DONE);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q        <= IDLE;
      addr_mem_q     <= '0;
      wr_mem_q       <= '0;
      rd_data_q      <= '0;
      rd_pend_q      <= 1'b0;
      rd_pend_addr_q <= '0;
      cnt_q          <= '0;
      wr_enable_q    <= 1'b0;
      wr_done_q      <= 1'b0;
      rd_done_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_mem_q     <= addr_mem_d;
      wr_mem_q       <= wr_mem_d;
      rd_data_q      <= rd_data_d;
      rd_pend_q      <= rd_pend_d;
      rd_pend_addr_q <= rd_pend_addr_d;
      cnt_q          <= cnt_d;
      wr_enable_q    <= wr_enable_d;
      wr_done_q      <= wr_done_d;
      rd_done_q      <= rd_done_d;
    end
  end

  assign addr_mem  = addr_mem_q;
  assign wr_mem    = wr_mem_q;
  assign wr_enable = wr_enable_q;
  assign wr_done   = wr_done_q;
  assign rd_done   = rd_done_q;
  assign rd_data   = rd_data_q;
  assign busy      = (state_q != IDLE) | rd_pend_q;

endmodule

// File: tb/tb_mem_rw_interface.sv
// Directed bench: a 32x8 RD_LAT=2 controller and a 256x8 RD_LAT=1 controller,
// each in front of a behavioural memory whose data is only valid once stable.
module tb_mem_rw_interface;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 32x8 message RAM, RD_LAT=2
  logic       wr_start_a, rd_start_a;
  logic [4:0] wr_addr_a, rd_addr_a, addr_a;
  logic [7:0] wr_data_a, rd_mem_a, wr_mem_a, rd_data_a;
  logic       wr_en_a, wr_done_a, rd_done_a, busy_a;

  // 256x8 S-array, RD_LAT=1
  logic       wr_start_s, rd_start_s;
  logic [7:0] wr_addr_s, rd_addr_s, addr_s;
  logic [7:0] wr_data_s, rd_mem_s, wr_mem_s, rd_data_s;
  logic       wr_en_s, wr_done_s, rd_done_s, busy_s;

  mem_rw_interface #(.ADDR_W(5), .DATA_W(8), .RD_LAT(2)) dut (
    .clk(clk), .nreset(nreset),
    .wr_start(wr_start_a), .wr_addr_in(wr_addr_a), .wr_data_in(wr_data_a),
    .rd_start(rd_start_a), .rd_addr_in(rd_addr_a), .rd_mem(rd_mem_a),
    .addr_mem(addr_a), .wr_mem(wr_mem_a), .wr_enable(wr_en_a),
    .wr_done(wr_done_a), .rd_done(rd_done_a), .rd_data(rd_data_a), .busy(busy_a)
  );

  mem_rw_interface #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut_s (
    .clk(clk), .nreset(nreset),
    .wr_start(wr_start_s), .wr_addr_in(wr_addr_s), .wr_data_in(wr_data_s),
    .rd_start(rd_start_s), .rd_addr_in(rd_addr_s), .rd_mem(rd_mem_s),
    .addr_mem(addr_s), .wr_mem(wr_mem_s), .wr_enable(wr_en_s),
    .wr_done(wr_done_s), .rd_done(rd_done_s), .rd_data(rd_data_s), .busy(busy_s)
  );

  // Memory models: contents loaded on the first edge; data returns 8'hEE
  // unless the address has been held for the full latency.
  logic [7:0] mem_a [32];
  logic [4:0] pa [2];
  bit         loaded_a;
  always @(posedge clk) begin
    if (!loaded_a) begin
      for (int i = 0; i < 32; i++) mem_a[i] <= 8'(8'h10 + i);
      mem_a[4] <= 8'h3C;
      loaded_a <= 1'b1;
    end else if (wr_en_a) begin
      mem_a[addr_a] <= wr_mem_a;
    end
    pa[0] <= addr_a;
    pa[1] <= pa[0];
  end
  assign rd_mem_a = (pa[0] == pa[1]) ? mem_a[pa[1]] : 8'hEE;

  logic [7:0] mem_s [256];
  logic [7:0] ps;
  bit         loaded_s;
  always @(posedge clk) begin
    if (!loaded_s) begin
      for (int i = 0; i < 256; i++) mem_s[i] <= ~8'(i);
      mem_s[8'hC8] <= 8'h9D;
      loaded_s <= 1'b1;
    end else if (wr_en_s) begin
      mem_s[addr_s] <= wr_mem_s;
    end
    ps <= addr_s;
  end
  assign rd_mem_s = mem_s[ps];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_start_a = 0; rd_start_a = 0; wr_addr_a = '0; rd_addr_a = '0; wr_data_a = '0;
    wr_start_s = 0; rd_start_s = 0; wr_addr_s = '0; rd_addr_s = '0; wr_data_s = '0;
  endtask

  task automatic test_reset();
    nreset = 0;
    wr_start_a = 1; rd_start_a = 1; wr_addr_a = 5'h1F; rd_addr_a = 5'h0A; wr_data_a = 8'hFF;
    wr_start_s = 1; rd_start_s = 1; wr_addr_s = 8'hFF; rd_addr_s = 8'h0A; wr_data_s = 8'hFF;
    tick(); tick();
    checks++;
    if ({addr_a, wr_mem_a, wr_en_a, wr_done_a, rd_done_a, rd_data_a, busy_a} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_a got addr=%h wm=%h we=%b wd=%b rd=%b rdat=%h busy=%b exp all 0",
               addr_a, wr_mem_a, wr_en_a, wr_done_a, rd_done_a, rd_data_a, busy_a);
    end
    checks++;
    if ({addr_s, wr_mem_s, wr_en_s, wr_done_s, rd_done_s, rd_data_s, busy_s} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_s got addr=%h wm=%h we=%b wd=%b rd=%b rdat=%h busy=%b exp all 0",
               addr_s, wr_mem_s, wr_en_s, wr_done_s, rd_done_s, rd_data_s, busy_s);
    end
    idle_inputs();
    nreset = 1;
    tick();
    checks++;
    if ({busy_a, busy_s, wr_en_a, rd_done_a} !== 4'b0) begin
      errors++;
      $display("FAIL reset_release got busy_a=%b busy_s=%b we=%b rd=%b exp 0", busy_a, busy_s, wr_en_a, rd_done_a);
    end
  endtask

  task automatic test_write();
    wr_start_a = 1; wr_addr_a = 5'h1F; wr_data_a = 8'hA5;
    for (int k = 1; k <= 4; k++) begin
      tick();
      wr_start_a = 0; wr_addr_a = '0; wr_data_a = '0;
      checks++;
      if (wr_en_a !== (k == 1) || wr_done_a !== (k == 2) || busy_a !== (k < 3)) begin
        errors++;
        $display("FAIL write_strobes k=%0d got we=%b wd=%b busy=%b", k, wr_en_a, wr_done_a, busy_a);
      end
      if (k == 1) begin
        checks++;
        if (addr_a !== 5'h1F || wr_mem_a !== 8'hA5) begin
          errors++;
          $display("FAIL write_addr_data got addr=%h data=%h exp 1f a5", addr_a, wr_mem_a);
        end
      end
    end
  endtask

  task automatic test_read();
    rd_start_a = 1; rd_addr_a = 5'h04;
    for (int k = 1; k <= 6; k++) begin
      tick();
      rd_start_a = 0; rd_addr_a = '0;
      checks++;
      if (rd_done_a !== (k == 4) || wr_en_a !== 1'b0 || busy_a !== (k < 5)) begin
        errors++;
        $display("FAIL read_strobes k=%0d got rd=%b we=%b busy=%b", k, rd_done_a, wr_en_a, busy_a);
      end
      if (k >= 4) begin
        checks++;
        if (rd_data_a !== 8'h3C) begin
          errors++;
          $display("FAIL read_data k=%0d got %h exp 3c", k, rd_data_a);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    wr_start_a = 1; wr_addr_a = 5'h02; wr_data_a = 8'h77;
    rd_start_a = 1; rd_addr_a = 5'h02;
    for (int k = 1; k <= 8; k++) begin
      tick();
      idle_inputs();
      checks++;
      if (wr_en_a !== (k == 1) || wr_done_a !== (k == 2) || rd_done_a !== (k == 6) || busy_a !== (k < 7)) begin
        errors++;
        $display("FAIL simul_strobes k=%0d got we=%b wd=%b rd=%b busy=%b", k, wr_en_a, wr_done_a, rd_done_a, busy_a);
      end
      if (k == 6) begin
        checks++;
        if (rd_data_a !== 8'h77 || addr_a !== 5'h02) begin
          errors++;
          $display("FAIL simul_raw_data got data=%h addr=%h exp 77 02", rd_data_a, addr_a);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    // read request during WRITE is dropped
    wr_start_a = 1; wr_addr_a = 5'h03; wr_data_a = 8'h44;
    for (int k = 1; k <= 8; k++) begin
      tick();
      idle_inputs();
      if (k == 1) begin rd_start_a = 1; rd_addr_a = 5'h1F; end
      checks++;
      if (wr_done_a !== (k == 2) || rd_done_a !== 1'b0 || busy_a !== (k < 3)) begin
        errors++;
        $display("FAIL busy_wr_ignore k=%0d got wd=%b rd=%b busy=%b", k, wr_done_a, rd_done_a, busy_a);
      end
    end
    // read and write requests during RD_WAIT are dropped
    rd_start_a = 1; rd_addr_a = 5'h05;
    for (int k = 1; k <= 9; k++) begin
      tick();
      idle_inputs();
      if (k == 1 || k == 2) begin
        rd_start_a = 1; rd_addr_a = 5'h1F;
        wr_start_a = 1; wr_addr_a = 5'h05; wr_data_a = 8'hBB;
      end
      checks++;
      if (rd_done_a !== (k == 4) || wr_en_a !== 1'b0 || busy_a !== (k < 5)) begin
        errors++;
        $display("FAIL busy_rd_ignore k=%0d got rd=%b we=%b busy=%b", k, rd_done_a, wr_en_a, busy_a);
      end
    end
    checks++;
    if (rd_data_a !== 8'h15) begin
      errors++;
      $display("FAIL busy_rd_data got %h exp 15", rd_data_a);
    end
  endtask

  task automatic test_sarray_lat1();
    rd_start_s = 1; rd_addr_s = 8'hC8;
    for (int k = 1; k <= 5; k++) begin
      tick();
      idle_inputs();
      if (k == 1) begin rd_start_s = 1; rd_addr_s = 8'h00; end
      checks++;
      if (rd_done_s !== (k == 3) || busy_s !== (k < 4)) begin
        errors++;
        $display("FAIL sarray_read k=%0d got rd=%b busy=%b", k, rd_done_s, busy_s);
      end
    end
    checks++;
    if (rd_data_s !== 8'h9D) begin
      errors++;
      $display("FAIL sarray_read_data got %h exp 9d", rd_data_s);
    end
    wr_start_s = 1; wr_addr_s = 8'hFF; wr_data_s = 8'h5E;
    rd_start_s = 1; rd_addr_s = 8'hFF;
    for (int k = 1; k <= 7; k++) begin
      tick();
      idle_inputs();
      checks++;
      if (wr_done_s !== (k == 2) || rd_done_s !== (k == 5)) begin
        errors++;
        $display("FAIL sarray_simul k=%0d got wd=%b rd=%b", k, wr_done_s, rd_done_s);
      end
    end
    checks++;
    if (rd_data_s !== 8'h5E) begin
      errors++;
      $display("FAIL sarray_simul_data got %h exp 5e", rd_data_s);
    end
  endtask

  task automatic test_reset_mid_op();
    rd_start_a = 1; rd_addr_a = 5'h04;
    tick(); idle_inputs();
    tick();
    nreset = 0;
    tick();
    nreset = 1;
    checks++;
    if (rd_done_a !== 1'b0 || rd_data_a !== 8'h00 || busy_a !== 1'b0 || addr_a !== 5'h00) begin
      errors++;
      $display("FAIL reset_mid_read got rd=%b data=%h busy=%b addr=%h exp 0", rd_done_a, rd_data_a, busy_a, addr_a);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (rd_done_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_read_after k=%0d got rd=%b busy=%b", k, rd_done_a, busy_a);
      end
    end
    // pending read discarded by reset during the write
    wr_start_a = 1; wr_addr_a = 5'h06; wr_data_a = 8'h66;
    rd_start_a = 1; rd_addr_a = 5'h06;
    tick(); idle_inputs();
    nreset = 0;
    tick();
    nreset = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (rd_done_a !== 1'b0 || wr_done_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_pending k=%0d got wd=%b rd=%b busy=%b", k, wr_done_a, rd_done_a, busy_a);
      end
    end
    rd_start_a = 1; rd_addr_a = 5'h04;
    for (int k = 1; k <= 5; k++) begin
      tick();
      idle_inputs();
      checks++;
      if (rd_done_a !== (k == 4)) begin
        errors++;
        $display("FAIL reset_recover k=%0d got rd=%b", k, rd_done_a);
      end
    end
    checks++;
    if (rd_data_a !== 8'h3C) begin
      errors++;
      $display("FAIL reset_recover_data got %h exp 3c", rd_data_a);
    end
  endtask

  initial begin
    nreset = 0;
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_start_while_busy();
    test_sarray_lat1();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_rw_interface.md
# mem_rw_interface

Parametrised single-port memory controller for the RC4 engine, handling both writes and latency-aware reads with a start/done handshake per direction. Replaces the write-only 32×8 message-RAM controller and can sit in front of the 256×8 S-array RAM or the 32×8 decrypted-message RAM. Both read and write requests may arrive in the same cycle: the write executes first and one read is queued behind it.

## Interface
- ADDR_W, 5: memory address width.
- DATA_W, 8: memory data width.
- RD_LAT, 2: cycles from `addr_mem` change to valid `rd_mem`; legal range 1..15. An elaboration-time assertion rejects 0.

Ports:
- clk  in  1  clock.
- nreset  in  1  reset; synchronous, active-low.
- wr_start  in  1  write request, sampled only while accepting.
- wr_addr_in  in  ADDR_W  write address, captured with `wr_start`.
- wr_data_in  in  DATA_W  write data, captured with `wr_start`.
- rd_start  in  1  read request, sampled only while accepting.
- rd_addr_in  in  ADDR_W  read address, captured with `rd_start`.
- rd_mem  in  DATA_W  memory read data.
- addr_mem  out  ADDR_W  registered memory address.
- wr_mem  out  DATA_W  registered memory write data.
- wr_enable  out  1  memory write strobe, one cycle.
- wr_done  out  1  one-cycle write-complete pulse.
- rd_done  out  1  one-cycle read-complete pulse.
- rd_data  out  DATA_W  captured read data, held until the next read capture.
- busy  out  1  high when not accepting; `busy = (state != IDLE) | rd_pend`.

## Operation
- States: IDLE, WRITE, WR_DONE, RD_WAIT, RD_CAP, RD_DONE.
- Starts are accepted only in IDLE. Starts in any other state are ignored; they are not queued.
- IDLE + `wr_start`:
  - Capture `wr_addr_in` into `addr_mem` and `wr_data_in` into `wr_mem`.
  - Go to WRITE. Inputs need not be held after the start cycle.
- IDLE + `rd_start` only:
  - Capture `rd_addr_in` into `addr_mem` and load the latency counter with RD_LAT−1.
  - Go to RD_WAIT.
- IDLE + both starts:
  - The write proceeds as above.
  - `rd_addr_in` is latched into `rd_pend_addr` and `rd_pend` is set.
- WRITE: `wr_enable`=1 for exactly one cycle, then go to WR_DONE.
- WR_DONE: `wr_done`=1. Next state:
  - If `rd_pend`: `addr_mem` ← `rd_pend_addr`, clear `rd_pend`, load the counter, go to RD_WAIT.
  - Otherwise go to IDLE.
- RD_WAIT: decrement the counter; at 0 go to RD_CAP. With RD_LAT=1 this state is occupied for one cycle.
- RD_CAP: `rd_data` ← `rd_mem`, then go to RD_DONE.
- RD_DONE: `rd_done`=1, then go to IDLE.
- `addr_mem` and `wr_mem` hold their last values in IDLE.
- `wr_enable` is never high outside WRITE.
- Unreachable state encodings go to IDLE and clear `rd_pend`.

## Timing
- Reset: state=IDLE. `addr_mem`, `wr_mem`, `rd_data`, `rd_pend`, `rd_pend_addr` and the counter are all 0. Every output is 0.
- Reset mid-operation aborts immediately. No done pulse is issued and a pending read is discarded.
- Write, with start at cycle T:
  - `addr_mem`/`wr_mem` valid from T+1.
  - `wr_enable` at T+1.
  - `wr_done` at T+2.
  - IDLE at T+3; the next start is accepted at T+3.
- Read, with start at T:
  - `addr_mem` valid from T+1.
  - `rd_mem` sampled at the end of cycle T+1+RD_LAT.
  - `rd_done` and valid `rd_data` at T+2+RD_LAT; this is read latency RD_LAT+2.
  - IDLE at T+3+RD_LAT.
- Simultaneous write and read at T:
  - `wr_done` at T+2.
  - `addr_mem` = read address from T+3.
  - `rd_done` at T+4+RD_LAT.
- `busy` is combinational from registered state. It is low exactly in the cycles where a start is accepted.

## Structure
- Package `mem_if_pkg` holds:
  - the state enum `mem_if_state_t`;
  - the constant `MEM_IF_MAX_RD_LAT` = 15;
  - the counter width derived from it.
- Single module. No sub-module: the latency counter is 4 bits inline.

## Test plan
- **Reset:** drive `nreset`=0 with all starts high → every output 0 and `busy`=0. Release reset → IDLE.
- **Write:** ADDR_W=5. `wr_start` with addr 5'h1F, data 8'hA5 at T → `wr_enable` only at T+1 with `addr_mem`=1F, `wr_mem`=A5; `wr_done` only at T+2.
- **Read:** RD_LAT=2. Memory model returns 8'h3C at addr 5'h04 after 2 cycles. `rd_start` at T → `rd_done` at T+4, `rd_data`=3C and held afterwards; `wr_enable` never high.
- **Simultaneous start:** write (0x02, 0x77) with read 0x02 → `wr_done` at T+2, `rd_done` at T+6, `rd_data`=77 (read-after-write ordering).
- **Start while busy:** `rd_start` pulsed during WRITE and RD_WAIT → ignored, with no extra `rd_done`. Repeat with RD_LAT=1 and ADDR_W=8/DATA_W=8 (S-array): read latency is 3.
- **Reset mid-read:** assert reset during RD_WAIT → no `rd_done`, `rd_data`=0. A subsequent read completes normally.
